// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Table entries use fixed maximum field widths so the package stays
// independent of the controller's RA_W/FS_W parameters. Narrower values are
// zero-extended into these fields.
package pipe_ctrl_pkg;

  localparam int HZ_RA_MAX_W = 8;  // widest supported register index
  localparam int HZ_FS_MAX_W = 4;  // widest supported stage index

  // Stage whose end makes a result forwardable.
  localparam logic [HZ_FS_MAX_W-1:0] RDY_ALU  = 4'd0;
  localparam logic [HZ_FS_MAX_W-1:0] RDY_LOAD = 4'd1;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // One in-flight register writer.
  typedef struct packed {
    logic                   valid;
    logic [HZ_RA_MAX_W-1:0] rd;
    logic                   we;
    logic [HZ_FS_MAX_W-1:0] rdy_stg;
  } hz_entry_t;

  // True when the entry will write register rs.
  function automatic logic hz_match(input hz_entry_t e, input logic [HZ_RA_MAX_W-1:0] rs);
    return e.valid && e.we && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_tracker.sv
// Stage-indexed table of in-flight writers (entry i = instruction in EX+i)
// plus the per-operand match/priority scan that yields stall and forward
// selects for the instruction currently in ID.
module hazard_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int FS_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,      // EX frozen by a multi-cycle op
  input  logic            insert,    // ID instruction issues into EX
  input  hz_entry_t       id_entry,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic            use_rs1,
  input  logic            use_rs2,
  output logic            hazard,
  output logic [FS_W-1:0] fwd_a,
  output logic [FS_W-1:0] fwd_b
);

  hz_entry_t tbl_q [DEPTH];
  hz_entry_t tbl_d [DEPTH];

  logic haz_a;
  logic haz_b;

  // Youngest matching writer (lowest index) decides; the loop runs oldest to
  // youngest so the youngest match is the last assignment. The WB entry is
  // not scanned because the regfile write-through bypass covers it.
  function automatic logic [FS_W:0] scan(input logic [RA_W-1:0] rs, input logic use_rs);
    logic [FS_W:0] r;
    r = {1'b0, FS_W'(FWD_RF)};
    if (use_rs && rs != '0) begin
      for (int i = DEPTH - 2; i >= 0; i--) begin
        if (hz_match(tbl_q[i], HZ_RA_MAX_W'(rs))) begin
          if (HZ_FS_MAX_W'(i) < tbl_q[i].rdy_stg) r = {1'b1, FS_W'(FWD_RF)};
          else                                    r = {1'b0, FS_W'(i + 1)};
        end
      end
    end
    return r;
  endfunction

  // Next table contents: shift one stage per cycle; under hold EX keeps its
  // entry and a bubble enters MEM.
  always_comb begin
    // NOTE: every tbl_d element is assigned on every path before any
    // conditional override, so no latch can be inferred.
    for (int i = 1; i < DEPTH; i++) tbl_d[i] = tbl_q[i-1];
    tbl_d[0] = insert ? id_entry : '0;
    if (hold) begin
      tbl_d[0] = tbl_q[0];
      tbl_d[1] = '0;
    end
  end

  // Table register.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this table is a handful of flops whose valid bits gate stalls,
      // so it must be reset, unlike a RAM-style storage array.
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every entry shifts from the pre-edge values.
      tbl_q <= tbl_d;
    end
  end

  // Operand scans for the ID instruction.
  always_comb begin
    {haz_a, fwd_a} = scan(rs1, use_rs1);
    {haz_b, fwd_b} = scan(rs2, use_rs2);
    hazard         = haz_a || haz_b;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order RISC-V pipeline.
// Produces load-use stalls, branch flushes, EX-aligned registered forward
// selects and an EX hold for long (multi-cycle) operations.
// Optional feature: define HAZARD_PERF_EN to add saturating stall/flush
// cycle counters (perf_stall, perf_flush).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int NREG     = 32,
  parameter int RA_W     = 5,
  parameter int LONG_LAT = 0,
  parameter int FS_W     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_we,
  input  logic [FS_W-1:0] id_rdy_stg,
  input  logic            id_long,
  input  logic            ex_redirect,
  output logic            stall_fe,
  output logic            flush_fe,
  output logic            bubble_ex,
  output logic            ex_hold,
  output logic [FS_W-1:0] fwd_a_sel,
  output logic [FS_W-1:0] fwd_b_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  localparam bit LONG_EN = (LONG_LAT >= 2);
  localparam int CNT_W   = LONG_EN ? $clog2(LONG_LAT) : 1;

  if (RA_W < $clog2(NREG) || RA_W > HZ_RA_MAX_W || DEPTH < 2 ||
      FS_W < $clog2(DEPTH) || FS_W > HZ_FS_MAX_W) begin : g_bad_params
    $error("pipe_hazard_ctrl: inconsistent parameters");
  end

  logic            hazard;
  logic            stall;
  logic            issue;
  hz_entry_t       id_entry;
  logic [FS_W-1:0] fwd_a;
  logic [FS_W-1:0] fwd_b;
  logic [FS_W-1:0] fwd_a_sel_q, fwd_a_sel_d;
  logic [FS_W-1:0] fwd_b_sel_q, fwd_b_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_tracker #(
    .DEPTH (DEPTH),
    .RA_W  (RA_W),
    .FS_W  (FS_W)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .hold     (ex_hold),
    .insert   (issue),
    .id_entry (id_entry),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .use_rs1  (id_use_rs1),
    .use_rs2  (id_use_rs2),
    .hazard   (hazard),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  // Pipeline control: redirect beats hold beats stall; a redirected ID
  // instruction is dropped even when it was stalled.
  always_comb begin
    ex_hold   = (cnt_q != '0);
    stall     = id_valid && hazard;
    stall_fe  = stall || ex_hold;
    bubble_ex = (stall || ex_redirect) && !ex_hold;
    flush_fe  = ex_redirect;
    issue     = id_valid && !stall && !ex_hold && !ex_redirect;

    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = HZ_RA_MAX_W'(id_rd);
    id_entry.we      = id_we;
    id_entry.rdy_stg = HZ_FS_MAX_W'(id_rdy_stg);
  end

  // Hold counter and forward selects: a long op loads LONG_LAT-1 extra EX
  // cycles; the selects follow the issuing instruction and freeze with EX.
  // A redirect does not clear the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (LONG_EN && issue && id_long) cnt_d = CNT_W'(LONG_LAT - 1);
    else if (cnt_q != '0)            cnt_d = cnt_q - 1'b1;

    fwd_a_sel_d = FS_W'(FWD_RF);
    fwd_b_sel_d = FS_W'(FWD_RF);
    if (ex_hold) begin
      fwd_a_sel_d = fwd_a_sel_q;
      fwd_b_sel_d = fwd_b_sel_q;
    end else if (issue) begin
      fwd_a_sel_d = fwd_a;
      fwd_b_sel_d = fwd_b;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      fwd_a_sel_q <= '0;
      fwd_b_sel_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end

  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating counts of front-end stall and flush cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_fe && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    if (flush_fe && perf_flush_q != '1) perf_flush_d = perf_flush_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (DEPTH=3, LONG_LAT=4).
// Each vector is one ID cycle: combinational outputs are checked mid-cycle,
// the expected registered forward selects are queued and compared after
// the clock edge.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic [1:0] rdy;
    logic       lng;
    logic       redir;
    logic       e_sfe;
    logic       e_fl;
    logic       e_bub;
    logic       e_hold;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_we, id_long, ex_redirect;
  logic [1:0] id_rdy_stg;
  logic       stall_fe, flush_fe, bubble_ex, ex_hold;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall, perf_flush;
  int unsigned exp_pstall, exp_pflush;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] fwd_exp_q[$];
  vec_t tbl [16];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .DEPTH    (3),
    .NREG     (32),
    .RA_W     (5),
    .LONG_LAT (4),
    .FS_W     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_rdy_stg  (id_rdy_stg),
    .id_long     (id_long),
    .ex_redirect (ex_redirect),
    .stall_fe    (stall_fe),
    .flush_fe    (flush_fe),
    .bubble_ex   (bubble_ex),
    .ex_hold     (ex_hold),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rst, input int v, input int rs1, input int u1,
                              input int rs2, input int u2, input int rd, input int we,
                              input int rdy, input int lng, input int redir,
                              input int e_sfe, input int e_fl, input int e_bub,
                              input int e_hold, input int e_fa, input int e_fb);
    vec_t t;
    t.rst = 1'(rst);   t.v = 1'(v);
    t.rs1 = 5'(rs1);   t.u1 = 1'(u1);
    t.rs2 = 5'(rs2);   t.u2 = 1'(u2);
    t.rd = 5'(rd);     t.we = 1'(we);
    t.rdy = 2'(rdy);   t.lng = 1'(lng);   t.redir = 1'(redir);
    t.e_sfe = 1'(e_sfe); t.e_fl = 1'(e_fl); t.e_bub = 1'(e_bub); t.e_hold = 1'(e_hold);
    t.e_fa = 2'(e_fa); t.e_fb = 2'(e_fb);
    return t;
  endfunction

  // One cycle: drive at posedge+1, check combinational outputs, queue the
  // registered expectation, then compare it after the edge.
  task automatic step(input string tag, input vec_t t);
    logic [3:0] e;
    reset = t.rst; id_valid = t.v;
    id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_rd = t.rd; id_we = t.we; id_rdy_stg = t.rdy; id_long = t.lng;
    ex_redirect = t.redir;
    #3;
    check({tag, "/stall_fe"},  32'(stall_fe),  32'(t.e_sfe));
    check({tag, "/flush_fe"},  32'(flush_fe),  32'(t.e_fl));
    check({tag, "/bubble_ex"}, 32'(bubble_ex), 32'(t.e_bub));
    check({tag, "/ex_hold"},   32'(ex_hold),   32'(t.e_hold));
    fwd_exp_q.push_back({t.e_fa, t.e_fb});
`ifdef HAZARD_PERF_EN
    if (t.rst) begin
      exp_pstall = 0;
      exp_pflush = 0;
    end else begin
      exp_pstall += 32'(t.e_sfe);
      exp_pflush += 32'(t.e_fl);
    end
`endif
    @(posedge clk);
    #1;
    if (fwd_exp_q.size() == 0) begin
      check({tag, "/fwd_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = fwd_exp_q.pop_front();
      check({tag, "/fwd_a_sel"}, 32'(fwd_a_sel), 32'(e[3:2]));
      check({tag, "/fwd_b_sel"}, 32'(fwd_b_sel), 32'(e[1:0]));
    end
`ifdef HAZARD_PERF_EN
    check({tag, "/perf_stall"}, perf_stall, exp_pstall);
    check({tag, "/perf_flush"}, perf_flush, exp_pflush);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           rst v rs1 u1 rs2 u2 rd we rdy lng rdr | sfe fl bub hold fa fb
    tbl[0]  = mk(0, 1,  2, 1,  0, 0,  5, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0); // lw  x5,(x2)
    tbl[1]  = mk(0, 1,  5, 1,  1, 1,  6, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0); // add x6,x5,x1 load-use
    tbl[2]  = mk(0, 1,  5, 1,  1, 1,  6, 1, 0, 0, 0,   0, 0, 0, 0, 2, 0); // retry: load in WB next
    tbl[3]  = mk(0, 1,  6, 1,  6, 1,  7, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1); // sub x7,x6,x6
    tbl[4]  = mk(0, 1,  1, 1,  2, 1,  8, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // add x8,x1,x2
    tbl[5]  = mk(0, 1,  7, 1,  8, 1,  9, 1, 0, 0, 0,   0, 0, 0, 0, 2, 1); // or  x9,x7,x8
    tbl[6]  = mk(0, 1,  3, 1,  0, 0,  0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0); // lw  x0,(x3)
    tbl[7]  = mk(0, 1,  0, 1,  0, 1,  1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // add x1,x0,x0
    tbl[8]  = mk(0, 1,  2, 1,  0, 0,  5, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0); // lw  x5,(x2)
    tbl[9]  = mk(0, 1,  2, 1,  3, 1, 10, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // add x10,x2,x3
    tbl[10] = mk(0, 1, 10, 1,  5, 0,  4, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0); // store, rs2 unused
    tbl[11] = mk(0, 1,  4, 1,  0, 0,  5, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0); // lw x5,(x4): we=0 rd=4 ahead
    tbl[12] = mk(0, 1,  5, 1,  5, 1,  6, 1, 0, 0, 1,   1, 1, 1, 0, 0, 0); // load-use + redirect
    tbl[13] = mk(0, 1,  6, 1,  6, 1, 11, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // x6 writer was dropped
    tbl[14] = mk(0, 0, 11, 1,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // invalid ID, would match
    tbl[15] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0); // redirect, empty ID

    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; id_rd = '0; id_we = 1'b0; id_rdy_stg = '0; id_long = 1'b0;
    ex_redirect = 1'b0;
`ifdef HAZARD_PERF_EN
    exp_pstall = 0;
    exp_pflush = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset/stall_fe",  32'(stall_fe),  32'd0);
    check("reset/flush_fe",  32'(flush_fe),  32'd0);
    check("reset/bubble_ex", 32'(bubble_ex), 32'd0);
    check("reset/ex_hold",   32'(ex_hold),   32'd0);
    check("reset/fwd_a_sel", 32'(fwd_a_sel), 32'd0);
    check("reset/fwd_b_sel", 32'(fwd_b_sel), 32'd0);
`ifdef HAZARD_PERF_EN
    check("reset/perf_stall", perf_stall, 32'd0);
    check("reset/perf_flush", perf_flush, 32'd0);
`endif

    for (int i = 0; i < 16; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Long op: 3 hold cycles, dependent ALU op waits and then forwards from MEM.
    step("long_issue", mk(0, 1,  1, 1,  2, 1, 12, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("long_hold%0d", i),
           mk(0, 1, 12, 1, 12, 1, 13, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0));
    step("long_dep", mk(0, 1, 12, 1, 12, 1, 13, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1));

    // Reset in the second hold cycle; held forward select must clear too.
    step("rst_issue", mk(0, 1, 13, 1,  1, 1, 12, 1, 0, 1, 0,   0, 0, 0, 0, 1, 0));
    step("rst_hold1", mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0));
    step("rst_hold2", mk(1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0));
    step("rst_after", mk(0, 1, 12, 1, 12, 1, 14, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
